xbar_out_lock: RTL
==================

Name: xbar_out_lock

Overview:
- Output-port side of the switch allocation loop; it consumes the binary grant index that the round-robin matrix arbiter produces.
- Presents the arbiter with a request vector built from valid input flits and locks the output onto the granted input for a whole packet (head to tail).
- Muxes the owner's flits into a one-entry registered output stage with valid/ready flow control.
- One instance per switch output port, between the input buffers and the output link.

Parameters:
- IN_N, 5, number of input ports / requestors (2..16).
- DATA_WIDTH, 8, flit payload width.
- IDX_W, $clog2(IN_N), width of the grant index and the owner index.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  IN_N  per-input flit valid.
- in_last_i  in  IN_N  per-input tail flag, qualified by in_valid_i.
- in_data_i  in  IN_N*DATA_WIDTH  flattened flits; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_ready_o  out  IN_N  per-input accept; at most one bit high.
- arb_req_o  out  IN_N  request vector to the arbiter.
- arb_grant_i  in  IDX_W  binary grant from the arbiter, combinational in the same cycle as arb_req_o.
- out_valid_o  out  1  output flit valid.
- out_last_o  out  1  output tail flag.
- out_data_o  out  DATA_WIDTH  output flit.
- out_ready_i  in  1  downstream accept.
- locked_o  out  1  high while the port is held mid-packet.
- owner_o  out  IDX_W  current or last owner index.
- err_o  out  1  sticky grant protocol error.

Behaviour:
- Reset: state IDLE. All of these are 0: out_valid_o, out_last_o, out_data_o, owner_o, locked_o, err_o, in_ready_o, arb_req_o.
- Reset mid-packet aborts the packet and drops any held flit. There is no partial-packet recovery.
- slot_free = !out_valid_o | out_ready_i. This is combinational and allows a full-throughput pipeline.
- A handshake on input k is in_valid_i[k] & in_ready_o[k]. On a handshake, the output register loads data, last and valid=1 on the next edge. Input-to-output latency is 1 cycle.
- If slot_free holds and no handshake occurs, out_valid_o clears to 0.
- If out_valid_o=1 and out_ready_i=0, the output holds data and last stable.
- IDLE state:
  - arb_req_o = in_valid_i when slot_free, else 0. Requests are never driven without immediate consumption, because the arbiter rotates priority on every nonzero grant.
  - g = arb_grant_i is valid when g < IN_N and arb_req_o[g] = 1.
  - If g is valid: in_ready_o[g]=1, owner_o <= g, handshake occurs.
  - If in_last_i[g]=1 (single-flit packet), stay in IDLE. Otherwise go to LOCKED and set locked_o <= 1.
  - If arb_req_o != 0 but g is invalid: no accept, err_o <= 1 (sticky until reset), stay in IDLE.
- LOCKED state:
  - arb_req_o = 0.
  - in_ready_o[owner_o] = slot_free; all other bits 0. Other inputs stall regardless of their valid.
  - On an owner handshake with in_last_i[owner_o]=1: go to IDLE, locked_o <= 0.
  - Owner valid low: hold the lock indefinitely (bubble), output drains normally.
- The tail handshake and the next arbitration never share a cycle. After a tail, arbitration resumes on the following cycle. Minimum inter-packet gap is 1 cycle when switching packets in LOCKED mode.
- in_data_i, in_last_i and the valid bits of non-ready inputs must not affect state.
- owner_o retains its last value in IDLE when no grant occurs.

Test Plan:
- Single-flit packet: in_valid_i=5'b00100, in_last_i[2]=1, data 8'hA5, arbiter grant=2, out_ready_i=1 -> in_ready_o=5'b00100 that cycle. Next cycle out_valid_o=1, out_data_o=8'hA5, out_last_o=1, locked_o=0.
- 3-flit packet from input 1 (11,22,33, last on 33) while input 3 is valid throughout -> locked_o=1 after the first flit. in_ready_o[3] stays 0 until the cycle after the 33 handshake. Output sequence 11,22,33 on consecutive cycles.
- Backpressure: out_ready_i=0 for 4 cycles with a flit held -> out_valid_o stays 1, data stable, arb_req_o=0 and in_ready_o=0 during the stall. Transfer completes 1 cycle after out_ready_i=1.
- Fairness loop with the real matrix arbiter: inputs 0,1,4 continuously send 1-flit packets -> owner_o sequence 0,1,4,0,1,4, no starvation.
- Bad grant: arb_req_o=5'b00010, arb_grant_i=3 -> no in_ready_o, err_o=1 and it stays 1 until rst_i.
- Asynchronous rst_i pulse mid-packet (LOCKED, out_valid_o=1) -> all outputs 0 immediately without a clock edge. State is IDLE on release.

Source files
------------

// File: rtl/xbar_out_lock.sv
// ============================================================================
//  Module   : xbar_out_lock
//  Brief    : Switch output port. Requests arbitration, locks onto the granted
//             input for a whole packet and registers flits into a one-entry
//             valid/ready output stage.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module xbar_out_lock #(
   parameter int IN_N       = 5,
   parameter int DATA_WIDTH = 8,
   parameter int IDX_W      = $clog2(IN_N)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [IN_N-1:0]            in_valid_i,
   input  logic [IN_N-1:0]            in_last_i,
   input  logic [IN_N*DATA_WIDTH-1:0] in_data_i,
   output logic [IN_N-1:0]            in_ready_o,
   output logic [IN_N-1:0]            arb_req_o,
   input  logic [IDX_W-1:0]           arb_grant_i,
   output logic                       out_valid_o,
   output logic                       out_last_o,
   output logic [DATA_WIDTH-1:0]      out_data_o,
   input  logic                       out_ready_i,
   output logic                       locked_o,
   output logic [IDX_W-1:0]           owner_o,
   output logic                       err_o
);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_LOCKED = 1'b1;

   logic [0:0]            r_state;
   logic                  r_out_valid;
   logic                  r_out_last;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [IDX_W-1:0]      r_owner;
   logic                  r_err;

   logic                  w_slot_free;
   logic [IN_N-1:0]       w_grant_hot;
   logic [IN_N-1:0]       w_owner_hot;
   logic [IN_N-1:0]       w_req;
   logic [IN_N-1:0]       w_ready;
   logic                  w_grant_ok;
   logic                  w_bad_grant;
   logic                  w_hs;
   logic                  w_sel_last;
   logic [DATA_WIDTH-1:0] w_sel_data;

   always_comb begin
      w_slot_free = !r_out_valid | out_ready_i;
      w_grant_hot = '0;
      w_owner_hot = '0;
      for (int k = 0; k < IN_N; k++) begin
         w_grant_hot[k] = (arb_grant_i == IDX_W'(k));
         w_owner_hot[k] = (r_owner == IDX_W'(k));
      end

      // Requests only go out when the slot can take a flit this cycle, since
      // the arbiter rotates priority on every nonzero grant.
      w_req = (!rst_i && r_state == S_IDLE && w_slot_free) ? in_valid_i : '0;
      // A grant index beyond IN_N has no matching hot bit, so it reads as invalid.
      w_grant_ok  = |(w_req & w_grant_hot);
      w_bad_grant = (|w_req) & !w_grant_ok;

      if (rst_i)
         w_ready = '0;
      else if (r_state == S_IDLE)
         w_ready = w_req & w_grant_hot;
      else
         w_ready = w_slot_free ? w_owner_hot : '0;

      w_hs       = |(in_valid_i & w_ready);
      w_sel_data = '0;
      w_sel_last = 1'b0;
      for (int k = 0; k < IN_N; k++) begin
         if (w_ready[k]) begin
            w_sel_data = in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            w_sel_last = in_last_i[k];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
         r_owner     <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_hs) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_sel_last;
            r_out_data  <= w_sel_data;
         end else if (w_slot_free) begin
            r_out_valid <= 1'b0;
         end

         if (w_bad_grant)
            r_err <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_grant_ok) begin
                  r_owner <= arb_grant_i;
                  if (!w_sel_last)
                     r_state <= S_LOCKED;
               end
            end
            S_LOCKED: begin
               // The tail releases the lock; arbitration resumes next cycle.
               if (w_hs && w_sel_last)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready_o  = w_ready;
   assign arb_req_o   = w_req;
   assign out_valid_o = r_out_valid;
   assign out_last_o  = r_out_last;
   assign out_data_o  = r_out_data;
   assign locked_o    = (r_state == S_LOCKED);
   assign owner_o     = r_owner;
   assign err_o       = r_err;

endmodule

`default_nettype wire
